// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-stage port bundle: execute/hazard inputs, I-cache request/response, decode-side outputs.
// master = pc_fetch_ctrl, slave = the surrounding pipeline and cache.
interface pc_fetch_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  stall;
  logic                  redirect;
  logic [DATA_WIDTH-1:0] redirect_target;
  logic                  ic_req;
  logic [DATA_WIDTH-1:0] ic_addr;
  logic                  ic_hit;
  logic                  ic_fill_done;
  logic                  if_valid;
  logic [DATA_WIDTH-1:0] if_pc;
  logic [DATA_WIDTH-1:0] if_inc_pc;
  logic                  flush;
  logic                  misalign_err;

  modport master (
    input  stall, redirect, redirect_target, ic_hit, ic_fill_done,
    output ic_req, ic_addr, if_valid, if_pc, if_inc_pc, flush, misalign_err
  );

  modport slave (
    output stall, redirect, redirect_target, ic_hit, ic_fill_done,
    input  ic_req, ic_addr, if_valid, if_pc, if_inc_pc, flush, misalign_err
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: owns the PC, looks it up in the I-cache, one instruction/cycle on hits.
// if_valid/flush are same-cycle combinational; stall holds the PC, misses hold until refill.
module pc_fetch_ctrl #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic            clk,
  input  logic            rst,
  pc_fetch_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    BOOT  = 3'd0,
    RUN   = 3'd1,
    MISS  = 3'd2,
    DRAIN = 3'd3,
    HALT  = 3'd4
  } state_t;

  localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic                  err_q, err_d;

  logic                  req;
  logic                  valid;
  logic                  flush;
  logic                  redirect_live;
  logic                  target_misaligned;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
    end
  end

  assign redirect_live     = bus.redirect && (state_q inside {RUN, MISS, DRAIN});
  assign target_misaligned = |bus.redirect_target[1:0];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    err_d   = err_q;
    req     = 1'b0;
    valid   = 1'b0;
    flush   = 1'b0;

    unique case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        req   = 1'b1;
        valid = bus.ic_hit;
        if (bus.ic_hit && !bus.stall) begin
          pc_d = pc_q + PC_STEP;
        end
        if (!bus.ic_hit) begin
          state_d = MISS;
        end
      end
      MISS: begin
        req = 1'b1;
        if (bus.ic_fill_done) begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (bus.ic_fill_done) begin
          state_d = RUN;
        end
      end
      HALT: begin
      end
      default: begin
        state_d = BOOT;
      end
    endcase

    // Redirect overrides everything above; a refill that lands in the same
    // cycle leaves nothing outstanding, so we go straight back to RUN.
    if (redirect_live) begin
      flush = 1'b1;
      valid = 1'b0;
      if (target_misaligned) begin
        pc_d    = pc_q;
        err_d   = 1'b1;
        state_d = HALT;
      end else begin
        pc_d    = bus.redirect_target;
        state_d = (state_q == RUN || bus.ic_fill_done) ? RUN : DRAIN;
      end
    end
  end

  assign bus.ic_req       = req   && !rst;
  assign bus.if_valid     = valid && !rst;
  assign bus.flush        = flush && !rst;
  assign bus.ic_addr      = pc_q;
  assign bus.if_pc        = pc_q;
  assign bus.if_inc_pc    = pc_q + PC_STEP;
  assign bus.misalign_err = err_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed vector table, then random traffic against a behavioural model.
module tb_pc_fetch_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pc_fetch_ctrl_if #(.DATA_WIDTH(32)) bus ();

  pc_fetch_ctrl #(
    .DATA_WIDTH(32),
    .RESET_PC  (32'h0000_0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        redir;
    logic [31:0] tgt;
    logic        hit;
    logic        fill;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic        flush;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic s, input logic rd, input logic [31:0] t,
                     input logic h, input logic f, input logic e_req, input logic [31:0] e_addr,
                     input logic e_valid, input logic e_flush, input logic e_err);
    vec_t v;
    v.rst = r; v.stall = s; v.redir = rd; v.tgt = t; v.hit = h; v.fill = f;
    v.req = e_req; v.addr = e_addr; v.valid = e_valid; v.flush = e_flush; v.err = e_err;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic rd, input logic [31:0] t,
                       input logic h, input logic f);
    rst                 = r;
    bus.stall           = s;
    bus.redirect        = rd;
    bus.redirect_target = t;
    bus.ic_hit          = h;
    bus.ic_fill_done    = f;
  endtask

  task automatic check_outputs(input string tag, input logic e_req, input logic [31:0] e_addr,
                               input logic e_valid, input logic e_flush, input logic e_err);
    logic [31:0] e_inc;
    e_inc = e_addr + 32'd4;
    check({tag, " ic_req"},       32'(bus.ic_req),       32'(e_req));
    check({tag, " ic_addr"},      bus.ic_addr,           e_addr);
    check({tag, " if_pc"},        bus.if_pc,             e_addr);
    check({tag, " if_inc_pc"},    bus.if_inc_pc,         e_inc);
    check({tag, " if_valid"},     32'(bus.if_valid),     32'(e_valid));
    check({tag, " flush"},        32'(bus.flush),        32'(e_flush));
    check({tag, " misalign_err"}, 32'(bus.misalign_err), 32'(e_err));
  endtask

  // Behavioural model: fetch mode described by what is outstanding, not by FSM states.
  logic [31:0] m_pc;
  logic        m_booting, m_waiting, m_orphan_fill, m_dead, m_err;

  task automatic model_reset();
    m_pc = 32'h0; m_booting = 1'b1; m_waiting = 1'b0;
    m_orphan_fill = 1'b0; m_dead = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_step(input logic r, input logic s, input logic rd, input logic [31:0] t,
                            input logic h, input logic f);
    if (r) begin
      model_reset();
    end else if (m_booting) begin
      m_booting = 1'b0;
    end else if (m_dead) begin
      m_dead = 1'b1;
    end else if (rd) begin
      if (t[1:0] != 2'b00) begin
        m_dead = 1'b1; m_err = 1'b1; m_waiting = 1'b0; m_orphan_fill = 1'b0;
      end else begin
        m_pc          = t;
        m_orphan_fill = (m_waiting || m_orphan_fill) && !f;
        m_waiting     = 1'b0;
      end
    end else if (m_orphan_fill) begin
      if (f) m_orphan_fill = 1'b0;
    end else if (m_waiting) begin
      if (f) m_waiting = 1'b0;
    end else begin
      if (h && !s) m_pc = m_pc + 32'd4;
      if (!h) m_waiting = 1'b1;
    end
  endtask

  initial begin
    logic        r_rst, r_stall, r_redir, r_hit, r_fill;
    logic [31:0] r_tgt;
    logic        e_req, e_valid, e_flush, e_active;

    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    @(posedge clk); #1;

    //   rst st rd tgt            hit fill | req addr          vld fl err
    add(1, 0, 0, 32'h0,          1, 0,    0, 32'h0,          0, 0, 0);
    add(0, 0, 0, 32'h0,          1, 0,    0, 32'h0,          0, 0, 0);
    add(0, 0, 0, 32'h0,          1, 0,    1, 32'h0,          1, 0, 0);
    add(0, 0, 0, 32'h0,          1, 0,    1, 32'h4,          1, 0, 0);
    add(0, 1, 0, 32'h0,          1, 0,    1, 32'h8,          1, 0, 0);
    add(0, 1, 0, 32'h0,          1, 0,    1, 32'h8,          1, 0, 0);
    add(0, 1, 0, 32'h0,          1, 0,    1, 32'h8,          1, 0, 0);
    add(0, 0, 0, 32'h0,          1, 0,    1, 32'h8,          1, 0, 0);
    add(0, 0, 0, 32'h0,          1, 0,    1, 32'hC,          1, 0, 0);
    add(0, 0, 0, 32'h0,          0, 0,    1, 32'h10,         0, 0, 0);
    add(0, 1, 0, 32'h0,          0, 0,    1, 32'h10,         0, 0, 0);
    add(0, 0, 0, 32'h0,          0, 0,    1, 32'h10,         0, 0, 0);
    add(0, 0, 0, 32'h0,          0, 0,    1, 32'h10,         0, 0, 0);
    add(0, 0, 0, 32'h0,          0, 1,    1, 32'h10,         0, 0, 0);
    add(0, 0, 0, 32'h0,          1, 0,    1, 32'h10,         1, 0, 0);
    add(0, 0, 0, 32'h0,          0, 0,    1, 32'h14,         0, 0, 0);
    add(0, 0, 0, 32'h0,          0, 0,    1, 32'h14,         0, 0, 0);
    add(0, 0, 1, 32'h100,        0, 0,    1, 32'h14,         0, 1, 0);
    add(0, 0, 0, 32'h0,          1, 0,    0, 32'h100,        0, 0, 0);
    add(0, 0, 0, 32'h0,          1, 1,    0, 32'h100,        0, 0, 0);
    add(0, 0, 0, 32'h0,          1, 0,    1, 32'h100,        1, 0, 0);
    add(0, 0, 0, 32'h0,          0, 0,    1, 32'h104,        0, 0, 0);
    add(0, 0, 1, 32'h200,        0, 1,    1, 32'h104,        0, 1, 0);
    add(0, 0, 0, 32'h0,          1, 0,    1, 32'h200,        1, 0, 0);
    add(0, 1, 1, 32'h40,         1, 0,    1, 32'h204,        0, 1, 0);
    add(0, 0, 0, 32'h0,          1, 0,    1, 32'h40,         1, 0, 0);
    add(0, 0, 1, 32'hFFFF_FFFC,  1, 0,    1, 32'h44,         0, 1, 0);
    add(0, 0, 0, 32'h0,          1, 0,    1, 32'hFFFF_FFFC,  1, 0, 0);
    add(0, 0, 0, 32'h0,          1, 0,    1, 32'h0,          1, 0, 0);
    add(0, 0, 1, 32'h102,        1, 0,    1, 32'h4,          0, 1, 0);
    add(0, 0, 0, 32'h0,          1, 0,    0, 32'h4,          0, 0, 1);
    add(0, 0, 1, 32'h300,        1, 1,    0, 32'h4,          0, 0, 1);
    add(1, 0, 0, 32'h0,          1, 0,    0, 32'h4,          0, 0, 1);
    add(0, 0, 0, 32'h0,          1, 0,    0, 32'h0,          0, 0, 0);
    add(0, 0, 0, 32'h0,          0, 0,    1, 32'h0,          0, 0, 0);
    add(0, 0, 1, 32'h80,         0, 0,    1, 32'h0,          0, 1, 0);
    add(1, 0, 0, 32'h0,          0, 0,    0, 32'h80,         0, 0, 0);
    add(0, 0, 0, 32'h0,          0, 1,    0, 32'h0,          0, 0, 0);
    add(0, 0, 0, 32'h0,          1, 0,    1, 32'h0,          1, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].stall, vecs[i].redir, vecs[i].tgt, vecs[i].hit, vecs[i].fill);
      @(negedge clk);
      check_outputs($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr,
                    vecs[i].valid, vecs[i].flush, vecs[i].err);
      @(posedge clk); #1;
    end

    // Random traffic from a fresh reset.
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    model_reset();
    @(posedge clk); #1;

    for (int c = 0; c < 4000; c++) begin
      r_rst   = ($urandom_range(0, 39) == 0);
      r_stall = ($urandom_range(0, 3) == 0);
      r_redir = ($urandom_range(0, 7) == 0);
      r_hit   = ($urandom_range(0, 3) != 0);
      r_fill  = ($urandom_range(0, 4) == 0);
      r_tgt   = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 15) == 0) r_tgt[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 31) == 0) r_tgt = 32'hFFFF_FFFC;
      drive(r_rst, r_stall, r_redir, r_tgt, r_hit, r_fill);

      e_active = !r_rst && !m_booting && !m_dead;
      e_req    = e_active && !m_orphan_fill;
      e_flush  = e_active && r_redir;
      e_valid  = e_req && !m_waiting && r_hit && !r_redir;

      @(negedge clk);
      check_outputs($sformatf("rnd%0d", c), e_req, m_pc, e_valid, e_flush, m_err);
      model_step(r_rst, r_stall, r_redir, r_tgt, r_hit, r_fill);
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
